// File: rtl/div_pkg.sv
// Shared types for the divider result path: converter FSM states and BCD digit type.
// Two BCD digits cover every remainder the 6-bit-max engine can produce.
package div_pkg;
  typedef enum logic [1:0] {
    IDLE,
    CONV_Q,
    CONV_R
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_DIGITS = 2;
endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by one.
// Purely combinational; the caller owns the engine register.
module bcd_dd_step
  import div_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [4*BCD_DIGITS+RW-1:0] eng_i,
  output logic [4*BCD_DIGITS+RW-1:0] eng_o
);

  localparam int EW = 4*BCD_DIGITS + RW;

  logic [EW-1:0] adj;

  always_comb begin
    adj = eng_i;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[RW+4*i +: 4] >= 4'd5) begin
        adj[RW+4*i +: 4] = adj[RW+4*i +: 4] + 4'd3;
      end
    end
    eng_o = adj << 1;
  end

endmodule

// File: rtl/div_result_bcd.sv
// Converts captured quotient then remainder to two BCD digits each, one bit per clock.
// done pulses 2*RW+2 cycles after the accepted start; start is ignored while busy.
module div_result_bcd
  import div_pkg::*;
#(
  parameter int QW = 4,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [QW-1:0] quotient,
  input  logic [RW-1:0] remainder,
  output logic [3:0]    q_tens,
  output logic [3:0]    q_ones,
  output logic [3:0]    r_tens,
  output logic [3:0]    r_ones,
  output logic          busy,
  output logic          done
);

  localparam int EW = 4*BCD_DIGITS + RW;
  localparam int CW = $clog2(RW + 1);

  state_e        state_q, state_d;
  logic [EW-1:0] eng_q, eng_d, eng_step;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] r_hold_q, r_hold_d;
  bcd_digit_t    q_tens_q, q_tens_d, q_ones_q, q_ones_d;
  bcd_digit_t    r_tens_q, r_tens_d, r_ones_q, r_ones_d;
  logic          done_q, done_d;

  bcd_dd_step #(.RW(RW)) u_step (
    .eng_i (eng_q),
    .eng_o (eng_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      eng_q    <= '0;
      cnt_q    <= '0;
      r_hold_q <= '0;
      q_tens_q <= '0;
      q_ones_q <= '0;
      r_tens_q <= '0;
      r_ones_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      eng_q    <= eng_d;
      cnt_q    <= cnt_d;
      r_hold_q <= r_hold_d;
      q_tens_q <= q_tens_d;
      q_ones_q <= q_ones_d;
      r_tens_q <= r_tens_d;
      r_ones_q <= r_ones_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    eng_d    = eng_q;
    cnt_d    = cnt_q;
    r_hold_d = r_hold_q;
    q_tens_d = q_tens_q;
    q_ones_d = q_ones_q;
    r_tens_d = r_tens_q;
    r_ones_d = r_ones_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_hold_d = remainder;
          eng_d    = EW'(quotient);
          cnt_d    = '0;
          state_d  = CONV_Q;
        end
      end
      CONV_Q: begin
        if (cnt_q == CW'(RW)) begin
          q_tens_d = eng_q[EW-1 -: 4];
          q_ones_d = eng_q[EW-5 -: 4];
          // Engine is reused for the remainder straight away, no idle gap.
          eng_d    = EW'(r_hold_q);
          cnt_d    = '0;
          state_d  = CONV_R;
        end else begin
          eng_d = eng_step;
          cnt_d = cnt_q + CW'(1);
        end
      end
      CONV_R: begin
        if (cnt_q == CW'(RW)) begin
          r_tens_d = eng_q[EW-1 -: 4];
          r_ones_d = eng_q[EW-5 -: 4];
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          eng_d = eng_step;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign q_tens = q_tens_q;
  assign q_ones = q_ones_q;
  assign r_tens = r_tens_q;
  assign r_ones = r_ones_q;

endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: timeline model of expected digits plus directed literal checks.
module tb_div_result_bcd;
  localparam int QW = 4;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [QW-1:0] quotient = '0;
  logic [RW-1:0] remainder = '0;
  logic [3:0]    q_tens, q_ones, r_tens, r_ones;
  logic          busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  div_result_bcd #(.QW(QW), .RW(RW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .quotient  (quotient),
    .remainder (remainder),
    .q_tens    (q_tens),
    .q_ones    (q_ones),
    .r_tens    (r_tens),
    .r_ones    (r_ones),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] lit(input int qt, input int qo, input int rt, input int ro,
                                      input bit b, input bit d);
    return {4'(qt), 4'(qo), 4'(rt), 4'(ro), b, d};
  endfunction

  function automatic logic [17:0] outs();
    return {q_tens, q_ones, r_tens, r_ones, busy, done};
  endfunction

  // Timeline model: edge k after acceptance; quotient shown at k=RW+1, remainder and done at k=2RW+2.
  int         m_cnt = 0;
  bit         m_busy = 0, m_done = 0;
  int         m_q = 0, m_r = 0;
  logic [3:0] e_qt = 0, e_qo = 0, e_rt = 0, e_ro = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_busy = 0; m_done = 0;
      e_qt = 0; e_qo = 0; e_rt = 0; e_ro = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_cnt = 0;
          m_q = int'(quotient); m_r = int'(remainder);
        end
      end else begin
        m_cnt++;
        if (m_cnt == RW + 1) begin
          e_qt = 4'(m_q / 10); e_qo = 4'(m_q % 10);
        end
        if (m_cnt == 2*RW + 2) begin
          e_rt = 4'(m_r / 10); e_ro = 4'(m_r % 10);
          m_done = 1; m_busy = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cycle_model", outs(), {e_qt, e_qo, e_rt, e_ro, m_busy, m_done});
  end

  task automatic start_conv(input int q, input int r);
    @(posedge clk); #1;
    start = 1'b1; quotient = QW'(q); remainder = RW'(r);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #(1ms);
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    #1 reset = 1'b0;
    #1 chk("reset_state", outs(), lit(0, 0, 0, 0, 0, 0));
    #20 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("idle_hold", outs(), lit(0, 0, 0, 0, 0, 0));

    start_conv(15, 31);
    chk("busy_after_start", outs(), lit(0, 0, 0, 0, 1, 0));
    wait_done(n);
    chk("latency_max", 18'(n), 18'(12));
    chk("max_digits", outs(), lit(1, 5, 3, 1, 0, 1));
    @(posedge clk); #1;
    chk("done_one_cycle", outs(), lit(1, 5, 3, 1, 0, 0));

    start_conv(9, 10);
    repeat (5) @(posedge clk);
    #1 chk("before_e6", outs(), lit(1, 5, 3, 1, 1, 0));
    @(posedge clk);
    #1 chk("q_at_e6", outs(), lit(0, 9, 3, 1, 1, 0));
    wait_done(n);
    chk("latency_rest", 18'(n), 18'(6));
    chk("r_at_e12", outs(), lit(0, 9, 1, 0, 0, 1));

    start_conv(14, 25);
    repeat (2) @(posedge clk);
    #1 start = 1'b1; quotient = 4'd3; remainder = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(n);
    chk("latency_ignored_start", 18'(n), 18'(9));
    chk("ignore_busy_start", outs(), lit(1, 4, 2, 5, 0, 1));
    start = 1'b1; quotient = 4'd7; remainder = 5'd0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("accept_in_done", outs(), lit(1, 4, 2, 5, 1, 0));
    wait_done(n);
    chk("latency_back2back", 18'(n), 18'(12));
    chk("back2back_digits", outs(), lit(0, 7, 0, 0, 0, 1));

    start_conv(15, 31);
    repeat (7) @(posedge clk);
    #1 chk("mid_conv", outs(), lit(1, 5, 0, 0, 1, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset", outs(), lit(0, 0, 0, 0, 0, 0));
    #1 reset = 1'b1;
    start_conv(12, 20);
    wait_done(n);
    chk("latency_after_reset", 18'(n), 18'(12));
    chk("after_reset_digits", outs(), lit(1, 2, 2, 0, 0, 1));

    for (int q = 0; q < 16; q++) begin
      for (int r = 0; r < 32; r++) begin
        start_conv(q, r);
        wait_done(n);
        chk("sweep_latency", 18'(n), 18'(12));
        chk("sweep_digits", outs(), lit(q / 10, q % 10, r / 10, r % 10, 0, 1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_result_bcd.md
# div_result_bcd

Sequential binary-to-BCD converter sitting directly downstream of the restoring divider. On a start strobe it captures the divider's 4-bit quotient and 5-bit remainder, converts each to two BCD digits with a shared shift-and-add-3 (double-dabble) engine, and holds the four digits stable for the seven-segment display drivers. Conversion is iterative, one bit per clock, with a busy/done handshake toward the control path.

## Interface

Parameters:
- QW, 4: quotient width; must satisfy QW ≤ RW.
- RW, 5: remainder width and engine width; must satisfy RW ≤ 6 so that two BCD digits (max 99) suffice.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the port is named `reset`, and asserting it low clears all state immediately.
- start  input  1  conversion request, sampled only in IDLE.
- quotient  input  QW  divider quotient, captured on the accepted start edge.
- remainder  input  RW  divider remainder, captured on the accepted start edge.
- q_tens, q_ones  output  4 each  BCD digits of the quotient.
- r_tens, r_ones  output  4 each  BCD digits of the remainder.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when all four digits have updated.

## Operation

- States: IDLE, CONV_Q, CONV_R.
- IDLE with start=1 at edge E0:
  - Capture remainder into r_hold.
  - Load the engine with {8'b0, zero-extended quotient}.
  - Clear iteration counter; go to CONV_Q; busy=1.
- Engine step, one per edge:
  - For each BCD nibble ≥ 5, add 3.
  - Then shift the whole (8+RW)-bit register left by 1.
  - Increment counter.
- CONV_Q:
  - After RW steps (edges E1..E5 at default), edge E6 latches the engine's upper 8 bits into q_tens/q_ones.
  - Same edge E6 reloads the engine with {8'b0, r_hold}, clears the counter, goes to CONV_R.
- CONV_R:
  - Steps at E7..E11.
  - Edge E12 latches r_tens/r_ones, sets done=1, clears busy, returns to IDLE.
- Outputs hold their last converted values until the next completion.
  - Quotient digits update at E6, remainder digits at E12; intermediate engine values never appear on outputs.
- start while busy=1 is ignored; no queueing.
- start=1 in the cycle where done=1 (state already IDLE) is accepted normally.
- quotient/remainder changes after E0 have no effect on the running conversion.
- Zero input converts to digits 0,0; maximum inputs 15 → 1,5 and 31 → 3,1.

## Timing

- Reset values: q_tens=q_ones=r_tens=r_ones=0, busy=0, done=0, state=IDLE, counter=0.
- Reset asserted mid-conversion aborts it; outputs return to 0 asynchronously.
- Latency: done high in the cycle after E(2·RW+2), i.e. 12 cycles after the start edge at default.
  - Next start can be accepted on that same edge.
- busy is high from after E0 through E12, for 2·RW+2 = 12 cycles.
- done is registered, exactly 1 cycle wide, never high while busy=1.

## Structure

- Shared package div_pkg holds:
  - the state enum (IDLE, CONV_Q, CONV_R);
  - the BCD digit typedef (4-bit);
  - the constant BCD_DIGITS=2.
- Sub-module bcd_dd_step: combinational add-3-then-shift of one (8+RW)-bit engine word.
  - The top block owns the register, counter, and FSM, and instantiates bcd_dd_step once.

## Test plan

- Reset then idle → all digits 0, busy=0, done=0; start held low for 20 cycles → no change.
- quotient=15, remainder=31, start pulse → busy for 12 cycles; done at cycle 12; q=1,5 and r=3,1.
- quotient=9, remainder=10 → q_ones updates at E6 with value 9 while r digits still show the previous values; at E12 r=1,0.
- start re-pulsed at cycle 4 with quotient=3 → ignored, result reflects the first operands; start during the done cycle with quotient=7, remainder=0 → accepted, result 0,7 / 0,0 after 12 more cycles.
- reset pulled low at cycle 8 of a conversion → outputs 0 immediately; after release, a fresh start with 12/20 → 1,2 / 2,0.
- Exhaustive sweep of quotient 0..15 × remainder 0..31 against a tens/ones reference model → all 512 cases match.
